// File: rtl/accumulator_3_if.sv
// Operand/result handshake bundle for accumulator_3.
// Both sides use strict valid/ready. A transfer happens on a rising clock edge
// where valid and ready are both high. A source holds its valid and payload
// stable until that edge. A sink may drive ready independently of valid.
interface accumulator_3_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] y;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] acc;
    logic       carry;
    logic [3:0] carry_cnt;

    // Upstream producer and downstream consumer side
    modport master (
        output in_valid, y, c_in, out_ready,
        input  in_ready, out_valid, acc, carry, carry_cnt
    );

    // Accumulator side
    modport slave (
        input  in_valid, y, c_in, out_ready,
        output in_ready, out_valid, acc, carry, carry_cnt
    );
endinterface

// File: rtl/accumulator_3.sv
// 3-bit accumulator built on a ripple-carry adder.
// The registered sum is fed back as the adder's x operand.
// Each result is presented once through a valid/ready handshake.
// A 4-bit saturating counter tracks how many additions carried out.

// Ripple-carry 3-bit adder: {c_out, s} = x + y + c_in
module full_adder_3 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       c_in,
    output logic [2:0] s,
    output logic       c_out
);
    logic [3:0] c;

    // Chain of one-bit full adders
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < 3; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
        c_out = c[3];
    end
endmodule

module accumulator_3 (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    accumulator_3_if.slave   bus,
    output logic             state_dbg
);
    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [3:0] carry_cnt_q, carry_cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic [2:0] sum_s;
    logic       sum_c_out;

    full_adder_3 u_adder (
        .x     (acc_q),
        .y     (bus.y),
        .c_in  (bus.c_in),
        .s     (sum_s),
        .c_out (sum_c_out)
    );

    // Next-state logic: clear overrides handshake; ACCEPT captures, PRESENT waits for ack
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        carry_cnt_d = carry_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = ST_ACCEPT;
            acc_d       = '0;
            carry_d     = 1'b0;
            carry_cnt_d = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (bus.in_valid) begin
                        acc_d   = sum_s;
                        carry_d = sum_c_out;
                        if (sum_c_out && (carry_cnt_q != 4'd15)) begin
                            carry_cnt_d = carry_cnt_q + 4'd1;
                        end
                        state_d     = ST_PRESENT;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (bus.out_ready) begin
                        state_d     = ST_ACCEPT;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_ACCEPT;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; handshake outputs are registered so they depend on state only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCEPT;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            carry_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            carry_cnt_q <= carry_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.carry_cnt = carry_cnt_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_accumulator_3.sv
// Bench for accumulator_3: scenario tasks, reference model feeding an expected queue.
module tb_accumulator_3;
    logic clock;
    logic reset;
    logic clear;
    logic state_dbg;

    accumulator_3_if bus ();

    accumulator_3 dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state and expected results {carry_cnt, carry, acc}
    logic [2:0] m_acc;
    logic       m_carry;
    logic [3:0] m_cnt;
    logic [7:0] exp_q[$];

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        m_acc   = '0;
        m_carry = 1'b0;
        m_cnt   = '0;
        exp_q.delete();
    endtask

    // Driver: offer one operand (called at a negedge), push model result
    task automatic send_op(input logic [2:0] yv, input logic cv);
        int n;
        logic [3:0] sum;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%b required=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.y        = yv;
        bus.c_in     = cv;
        sum = {1'b0, m_acc} + {1'b0, yv} + {3'b000, cv};
        m_acc   = sum[2:0];
        m_carry = sum[3];
        if (sum[3] && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        exp_q.push_back({m_cnt, m_carry, m_acc});
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    // Monitor/acceptor: wait for a result, stall 'hold' cycles, compare with queue, ack it
    task automatic get_result(input int hold);
        int n;
        logic [7:0] exp;
        logic [7:0] got;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < hold; i++) @(negedge clock);
        got = {bus.carry_cnt, bus.carry, bus.acc};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.out_valid !== 1'b1 || got !== exp) begin
            failures++;
            $display("FAIL result: valid=%b cnt/carry/acc=%h required valid=1 %h",
                     bus.out_valid, got, exp);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_ack: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc !== 3'd0 ||
            bus.carry !== 1'b0 || bus.carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_hold: rdy=%b vld=%b acc=%0d c=%b cnt=%0d required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.acc, bus.carry, bus.carry_cnt);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        // Move into PRESENT with nonzero state, then reset asynchronously mid-cycle
        send_op(3'd6, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc !== 3'd0 ||
            bus.carry !== 1'b0 || bus.carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_async: rdy=%b vld=%b acc=%0d c=%b cnt=%0d required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.acc, bus.carry, bus.carry_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_bit1();
        send_op(3'd2, 1'b0);
        checks++;
        if (bus.acc !== 3'd2) begin
            failures++;
            $display("FAIL bit1_acc: acc=%0d required 2", bus.acc);
        end
        get_result(0);
    endtask

    task automatic test_wrap();
        do_clear();
        bus.out_ready = 1'b0;
        send_op(3'd3, 1'b0);
        get_result(0);
        send_op(3'd5, 1'b0);
        checks++;
        if (bus.acc !== 3'd0 || bus.carry !== 1'b1 || bus.carry_cnt !== 4'd1) begin
            failures++;
            $display("FAIL wrap: acc=%0d carry=%b cnt=%0d required 0 1 1",
                     bus.acc, bus.carry, bus.carry_cnt);
        end
        get_result(0);
    endtask

    task automatic test_carry_in();
        send_op(3'd7, 1'b1);
        checks++;
        if (bus.acc !== 3'd0 || bus.carry !== 1'b1) begin
            failures++;
            $display("FAIL cin_a: acc=%0d carry=%b required 0 1", bus.acc, bus.carry);
        end
        get_result(0);
        send_op(3'd1, 1'b1);
        checks++;
        if (bus.acc !== 3'd2 || bus.carry !== 1'b0) begin
            failures++;
            $display("FAIL cin_b: acc=%0d carry=%b required 2 0", bus.acc, bus.carry);
        end
        get_result(0);
    endtask

    task automatic test_backpressure();
        logic [2:0] held;
        send_op(3'd3, 1'b0);
        held = m_acc;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.y        = 3'($urandom_range(0, 7));
            bus.c_in     = 1'($urandom_range(0, 1));
            @(negedge clock);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== held) begin
                failures++;
                $display("FAIL stall: vld=%b rdy=%b acc=%0d required 1 0 %0d",
                         bus.out_valid, bus.in_ready, bus.acc, held);
            end
        end
        bus.in_valid = 1'b0;
        get_result(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            send_op(3'd7, 1'b1);
            get_result(0);
        end
        checks++;
        if (bus.carry_cnt !== 4'd15) begin
            failures++;
            $display("FAIL saturate: cnt=%0d required 15", bus.carry_cnt);
        end
    endtask

    task automatic test_clear_present();
        do_clear();
        send_op(3'd5, 1'b0);
        clear         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.y         = 3'd1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        checks++;
        if (bus.acc !== 3'd0 || bus.carry_cnt !== 4'd0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear: acc=%0d cnt=%0d vld=%b rdy=%b required 0 0 0 1",
                     bus.acc, bus.carry_cnt, bus.out_valid, bus.in_ready);
        end
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.acc !== 3'd0) begin
            failures++;
            $display("FAIL clear_consumed: vld=%b acc=%0d required 0 0", bus.out_valid, bus.acc);
        end
        send_op(3'd1, 1'b0);
        get_result(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            send_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            get_result(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.y         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        test_reset();
        test_bit1();
        test_wrap();
        test_carry_in();
        test_backpressure();
        test_saturation();
        test_clear_present();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: queued=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accumulator_3.md
# accumulator_3

Sequential 3-bit accumulator that sits directly downstream of the `full_adder_3` ripple adder. It registers that adder's sum and carry-out and feeds the registered sum back as the adder's `x` operand, so a stream of 3-bit operands is summed modulo 8. Results go downstream through a valid/ready handshake. A saturating counter records how many additions produced a carry-out.

## Interface
- No parameters; width fixed at 3 bits (matches `full_adder_3`).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear of accumulator, carry, counter and handshake state.
- `in_valid`  in  1  operand `y`/`c_in` valid.
- `in_ready`  out  1  block can accept an operand this cycle.
- `y`  in  3  operand added to the accumulator.
- `c_in`  in  1  carry-in for this addition.
- `out_valid`  out  1  `acc`/`carry` hold a fresh result.
- `out_ready`  in  1  downstream accepts the result.
- `acc`  out  3  registered accumulator value (sum bits `s[2:0]`).
- `carry`  out  1  registered carry-out (`c_out`) of the last addition.
- `carry_cnt`  out  4  count of additions with carry-out; saturates at 15.

## Operation
- Internally instantiates `full_adder_3` with `x=acc`, `y=y`, `c_in=c_in`. Its outputs `s` and `c_out` are the next-state values.
- Arithmetic: `{c_out, s} = acc + y + c_in`, 4-bit result. `acc` takes the low 3 bits (wraps mod 8). `carry` takes bit 3.
- Two-state FSM:
  - ACCEPT: `in_ready=1`, `out_valid=0`. On `in_valid=1`:
    - `acc <= s`, `carry <= c_out`.
    - If `c_out=1` and `carry_cnt<15`, `carry_cnt` increments.
    - Go to PRESENT.
    - With `in_valid=0`, all state holds.
  - PRESENT: `in_ready=0`, `out_valid=1`. `acc`, `carry` and `carry_cnt` hold. `in_valid` is ignored. On `out_ready=1`, go to ACCEPT.
- `in_ready` and `out_valid` are Moore outputs decoded from state only.
- `clear=1`, in any state:
  - `acc=0`, `carry=0`, `carry_cnt=0`, state ACCEPT.
  - Overrides a simultaneous `in_valid` (operand not consumed) and `out_ready`.
  - Any pending result is discarded.
- Priority: `reset` > `clear` > handshake.
- Reset values:
  - `acc=000`, `carry=0`, `carry_cnt=0000`.
  - State ACCEPT, so `in_ready=1` and `out_valid=0` during and after reset.
- Reset asserted mid-operation (either state) returns to reset values immediately, without waiting for a clock edge.
- `carry_cnt` at 15 with another carry stays at 15; it never wraps.
- `carry` reflects only the most recent addition. It is not sticky.

## Timing
- Operand accepted on the rising edge where state=ACCEPT and `in_valid=1`.
- `acc`/`carry` update and `out_valid` rises on that same edge, so the result is visible the cycle after the `in_valid` cycle (latency 1).
- Result accepted on the edge where `out_valid=1` and `out_ready=1`. `in_ready=1` from the next cycle.
- Maximum throughput: one operand every 2 cycles with `out_ready` held high.
- Backpressure: `out_valid`, `acc` and `carry` remain stable until accepted; no result is lost or overwritten.
- `clear` takes effect on the next edge. Outputs show cleared values the following cycle.
- No combinational path from `in_valid`/`y`/`c_in` or from `out_ready` to any output.

## Test plan
- Reset, plus an operand with bit 1 only set:
  - Assert `reset` asynchronously mid-cycle -> `acc=0`, `carry=0`, `carry_cnt=0`, `in_ready=1`, `out_valid=0` without a clock edge.
  - After release, `y=2`, `c_in=0` -> `acc=2`. Checks that operand bit 1 reaches the adder correctly.
- Accumulate with wrap, `out_ready=1`:
  - `y=3`, `c_in=0` -> `acc=3`, `carry=0`.
  - Then `y=5`, `c_in=0` -> `acc=0`, `carry=1`, `carry_cnt=1`.
- Carry-in path: from `acc=0`, `y=7`, `c_in=1` -> `acc=0`, `carry=1`. Then `y=1`, `c_in=1` -> `acc=2`, `carry=0`.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles after an accepted operand -> `out_valid=1`, `in_ready=0`, `acc` stable.
  - Toggling `in_valid`/`y` has no effect.
  - Raising `out_ready` -> `in_ready=1` the next cycle.
- Saturation: 20 accepted additions each of `y=7`, `c_in=1` (each has carry-out) -> `carry_cnt` reaches 15 and stays 15.
- Clear in PRESENT:
  - With `acc=5`, `out_valid=1`, assert `clear` together with `in_valid=1` and `out_ready=1` -> next cycle `acc=0`, `carry_cnt=0`, `out_valid=0`, `in_ready=1`.
  - The simultaneous operand is not consumed.
